mdu_seq: RTL and testbench

- Parametrised multi-cycle multiply/divide unit for the EX stage of the pipelined MIPS core.
- Successor to the single-cycle combinational custom ALU. It adds signed and unsigned mult/div, HI/LO architectural registers, MTHI/MTLO writes, a fixed-latency busy handshake and cancellation.
- The decode/hazard unit stalls any MFHI/MFLO/MDU instruction while (start | busy).

---
 rtl/mdu_seq_pkg.sv | 37 +++
 rtl/mdu_divider.sv | 92 +++++++++
 rtl/mdu_seq.sv | 125 ++++++++++++
 tb/tb_mdu_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the multiply/divide unit: op and state encodings
// plus small decode helpers also used by the EX-stage decoder and hazard unit.
package mdu_defs;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  // Encodings 0..3 are the multi-cycle arithmetic ops; bit 1 selects divide,
  // bit 0 selects unsigned.
  function automatic logic is_arith(input logic [2:0] op);
    return !op[2];
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return !op[2] && op[1];
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return !op[0];
  endfunction

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Iterative restoring divider (signed/unsigned) that retires several quotient
// bits per cycle so the whole division fits inside CYCLES clock edges.
module mdu_divider
  import mdu_defs::*;
#(
  parameter int WIDTH  = 32,
  parameter int CYCLES = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int BPC   = ceil_div(WIDTH, CYCLES);
  localparam int STEPS = ceil_div(WIDTH, BPC);
  localparam int SW    = $clog2(STEPS + 1);

  logic [SW-1:0]    steps_left;
  logic [WIDTH-1:0] quo_q, rem_q, dvs_q, dividend_q;
  logic             neg_quo, neg_rem, div_zero;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] quo_n, rem_n;
  logic [WIDTH:0]   partial, diff;
  int               base;

  assign mag_a = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign mag_b = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  // The outputs reflect the state after the step taken at the coming edge,
  // so the parent can capture the final result on the last busy edge.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    quo_n   = quo_q;
    rem_n   = rem_q;
    partial = '0;
    diff    = '0;
    base    = (STEPS - int'(steps_left)) * BPC;
    if (steps_left != '0) begin
      for (int i = 0; i < BPC; i++) begin
        if (base + i < WIDTH) begin
          partial = {rem_n, quo_n[WIDTH-1]};
          diff    = partial - {1'b0, dvs_q};
          if (partial >= {1'b0, dvs_q}) begin
            rem_n = diff[WIDTH-1:0];
            quo_n = {quo_n[WIDTH-2:0], 1'b1};
          end else begin
            rem_n = partial[WIDTH-1:0];
            quo_n = {quo_n[WIDTH-2:0], 1'b0};
          end
        end
      end
    end
  end

  assign done      = (steps_left <= SW'(1));
  assign quotient  = div_zero ? '1 : (neg_quo ? -quo_n : quo_n);
  assign remainder = div_zero ? dividend_q : (neg_rem ? -rem_n : rem_n);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      steps_left <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      dividend_q <= '0;
      neg_quo    <= 1'b0;
      neg_rem    <= 1'b0;
      div_zero   <= 1'b0;
    end else if (start) begin
      steps_left <= SW'(STEPS);
      quo_q      <= mag_a;
      rem_q      <= '0;
      dvs_q      <= mag_b;
      dividend_q <= dividend;
      neg_quo    <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_rem    <= is_signed && dividend[WIDTH-1];
      div_zero   <= (divisor == '0);
    end else if (steps_left != '0) begin
      steps_left <= steps_left - SW'(1);
      quo_q      <= quo_n;
      rem_q      <= rem_n;
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit with HI/LO registers, MTHI/MTLO writes,
// a fixed-latency busy handshake and cancellation on exception flush.
module mdu_seq
  import mdu_defs::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  mdu_state_e         state, state_next;
  logic [CW-1:0]      count, count_next;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] a_ext, b_ext, product;
  logic [WIDTH-1:0]   div_quo, div_rem;
  logic               div_done;
  logic               idle_start, issue, mt_write, finish;

  assign idle_start = (state == IDLE) && start && !cancel;
  assign issue      = idle_start && is_arith(op);
  assign mt_write   = idle_start && ((op == MDU_MTHI) || (op == MDU_MTLO));
  assign finish     = (state == RUN) && !cancel && (count == CW'(1)) &&
                      (!is_div(op_q) || div_done);
  assign busy       = (state == RUN);

  // Sign- or zero-extend to 2*WIDTH so one multiplier serves MULT and MULTU.
  always_comb begin
    a_ext   = is_signed_op(op_q) ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext   = is_signed_op(op_q) ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    product = a_ext * b_ext;
  end

  mdu_divider #(
    .WIDTH  (WIDTH),
    .CYCLES (DIV_CYCLES)
  ) u_divider (
    .clk       (clk),
    .rst_n     (reset_n),
    .start     (issue && is_div(op)),
    .is_signed (is_signed_op(op)),
    .dividend  (A),
    .divisor   (B),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      IDLE: begin
        if (issue) begin
          state_next = RUN;
          count_next = is_div(op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end
      end
      RUN: begin
        // cancel wins over completion on the same edge
        if (cancel || finish) begin
          state_next = IDLE;
          count_next = '0;
        end else begin
          count_next = count - CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (issue) begin
      op_q <= op;
      a_q  <= A;
      b_q  <= B;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi <= '0;
      lo <= '0;
    end else if (finish) begin
      if (is_div(op_q)) begin
        hi <= div_rem;
        lo <= div_quo;
      end else begin
        {hi, lo} <= product;
      end
    end else if (mt_write) begin
      if (op == MDU_MTHI) hi <= A;
      else                lo <= A;
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq: arithmetic results, exact busy
// latency, MTHI/MTLO, cancel priority, ignored starts and asynchronous reset.
module tb_mdu_seq;

  localparam int WIDTH = 32;
  localparam int MULT_N = 5;
  localparam int DIV_N = 10;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A, B;
  logic             cancel;
  logic             busy;
  logic [WIDTH-1:0] hi, lo;

  int n_checks = 0;
  int n_pass   = 0;
  int cycles;

  mdu_seq #(
    .WIDTH       (WIDTH),
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .A       (A),
    .B       (B),
    .cancel  (cancel),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Drive one start pulse; returns #1 after the issuing edge.
  task automatic launch(input logic [2:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [WIDTH-1:0] a,
                     input logic [WIDTH-1:0] b, input int n_exp,
                     input logic [WIDTH-1:0] hi_exp, input logic [WIDTH-1:0] lo_exp);
    int n;
    launch(o, a, b);
    check({tag, " busy rises"}, WIDTH'(busy), 32'd1);
    wait_idle(n);
    check({tag, " latency"}, WIDTH'(n), WIDTH'(n_exp));
    check({tag, " hi"}, hi, hi_exp);
    check({tag, " lo"}, lo, lo_exp);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    op      = 3'd0;
    A       = '0;
    B       = '0;
    cancel  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", WIDTH'(busy), 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;

    run("MULT -1*2",     3'd0, 32'hFFFF_FFFF, 32'h2, MULT_N, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run("MULTU ffff*2",  3'd1, 32'hFFFF_FFFF, 32'h2, MULT_N, 32'h0000_0001, 32'hFFFF_FFFE);
    run("DIV -7/2",      3'd2, 32'hFFFF_FFF9, 32'h2, DIV_N,  32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("DIV 7/-2",      3'd2, 32'd7, 32'hFFFF_FFFE, DIV_N,  32'h0000_0001, 32'hFFFF_FFFD);
    run("DIVU 21/0",     3'd3, 32'd21, 32'd0, DIV_N, 32'd21, 32'hFFFF_FFFF);
    run("DIV -5/0",      3'd2, 32'hFFFF_FFFB, 32'd0, DIV_N, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run("DIV overflow",  3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 32'h0, 32'h8000_0000);
    run("DIVU big/16",   3'd3, 32'hFFFF_FFFF, 32'h10, DIV_N, 32'hF, 32'h0FFF_FFFF);

    launch(3'd4, 32'h1234, 32'h0);
    check("MTHI busy", WIDTH'(busy), 32'd0);
    check("MTHI hi", hi, 32'h1234);
    check("MTHI lo kept", lo, 32'h0FFF_FFFF);
    launch(3'd5, 32'h5678, 32'h0);
    check("MTLO busy", WIDTH'(busy), 32'd0);
    check("MTLO hi kept", hi, 32'h1234);
    check("MTLO lo", lo, 32'h5678);

    // Operands are latched at issue; later bus changes must not matter.
    launch(3'd1, 32'd21, 32'd12);
    A = 32'hFFFF_FFFF;
    B = 32'h7777_7777;
    wait_idle(cycles);
    check("MULTU latch latency", WIDTH'(cycles - 1 + 1), WIDTH'(MULT_N));
    check("MULTU latch hi", hi, 32'd0);
    check("MULTU latch lo", lo, 32'd252);

    launch(3'd0, 32'd3, 32'd4);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    check("cancel busy drop", WIDTH'(busy), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("cancel hi kept", hi, 32'd0);
    check("cancel lo kept", lo, 32'd252);

    launch(3'd0, 32'd3, 32'd4);
    repeat (MULT_N - 1) begin
      @(posedge clk);
      #1;
    end
    check("last-edge busy", WIDTH'(busy), 32'd1);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    check("last-edge cancel busy", WIDTH'(busy), 32'd0);
    check("last-edge cancel lo", lo, 32'd252);

    launch(3'd1, 32'd2, 32'd3);
    launch(3'd4, 32'hDEAD, 32'h0);
    check("start in RUN busy", WIDTH'(busy), 32'd1);
    wait_idle(cycles);
    check("start in RUN latency", WIDTH'(cycles + 1), WIDTH'(MULT_N));
    check("start in RUN hi", hi, 32'd0);
    check("start in RUN lo", lo, 32'd6);

    launch(3'd6, 32'hABCD, 32'h1);
    launch(3'd7, 32'hABCD, 32'h1);
    check("op 6/7 busy", WIDTH'(busy), 32'd0);
    check("op 6/7 hi", hi, 32'd0);
    check("op 6/7 lo", lo, 32'd6);

    cancel = 1'b1;
    launch(3'd4, 32'hBEEF, 32'h0);
    launch(3'd0, 32'd5, 32'd5);
    cancel = 1'b0;
    check("cancel+start busy", WIDTH'(busy), 32'd0);
    check("cancel+start hi", hi, 32'd0);

    launch(3'd3, 32'd100, 32'd7);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b0;
    #1;
    check("mid-DIV reset busy", WIDTH'(busy), 32'd0);
    check("mid-DIV reset hi", hi, 32'd0);
    check("mid-DIV reset lo", lo, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;

    run("DIVU 100/7", 3'd3, 32'd100, 32'd7, DIV_N, 32'd2, 32'd14);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
